// File: rtl/dbus_dispatch.sv
// Data-bus dispatcher: routes CPU data-port requests to one of NUM_TARGETS
// slaves, keeps up to DEPTH transactions in flight, and returns responses in
// order by only ever having a single target owning outstanding transactions.
module dbus_dispatch #(
    parameter int NUM_TARGETS = 2,
    parameter int DEPTH       = 2,
    parameter int ADDR_W      = 32,
    parameter int DATA_W      = 32,
    localparam int TW = (NUM_TARGETS > 1) ? $clog2(NUM_TARGETS) : 1,
    localparam int CW = $clog2(DEPTH + 1),
    localparam int SW = DATA_W / 8
) (
    input  logic                          clk_i,
    input  logic                          reset_i,
    input  logic                          up_req_i,
    input  logic                          up_wr_i,
    input  logic [1:0]                    up_size_i,
    input  logic [ADDR_W-1:0]             up_addr_i,
    input  logic [SW-1:0]                 up_strobe_i,
    input  logic [DATA_W-1:0]             up_wdata_i,
    input  logic [TW-1:0]                 up_target_i,
    output logic                          up_addr_ok_o,
    output logic                          up_data_ok_o,
    output logic [DATA_W-1:0]             up_rdata_o,
    output logic [NUM_TARGETS-1:0]        down_req_o,
    output logic                          down_wr_o,
    output logic [1:0]                    down_size_o,
    output logic [ADDR_W-1:0]             down_addr_o,
    output logic [SW-1:0]                 down_strobe_o,
    output logic [DATA_W-1:0]             down_wdata_o,
    input  logic [NUM_TARGETS-1:0]        down_addr_ok_i,
    input  logic [NUM_TARGETS-1:0]        down_data_ok_i,
    input  logic [NUM_TARGETS*DATA_W-1:0] down_rdata_i,
    output logic                          err_stray_o
);

    logic [CW-1:0] cnt_q, cnt_d;
    logic [TW-1:0] cur_q, cur_d;
    logic          err_q, err_d;

    logic                   resp;
    logic                   room;
    logic                   same;
    logic                   tgt_ok;
    logic                   issue;
    logic                   accept;
    logic                   stray;
    logic [NUM_TARGETS-1:0] cur_mask;

    // Broadcast request fields; only down_req selects which slave sees them.
    assign down_wr_o     = up_wr_i;
    assign down_size_o   = up_size_i;
    assign down_addr_o   = up_addr_i;
    assign down_strobe_o = up_strobe_i;
    assign down_wdata_o  = up_wdata_i;

    // Request/response decode: bypasses let a same-cycle response free a slot
    // or finish draining so the target can switch without a bubble.
    always_comb begin
        cur_mask = NUM_TARGETS'(1) << cur_q;
        resp     = down_data_ok_i[cur_q] && (cnt_q != '0);
        room     = (cnt_q < CW'(DEPTH)) || resp;
        same     = (cnt_q == '0) || (up_target_i == cur_q) ||
                   ((cnt_q == CW'(1)) && resp);
        // An index beyond the last slave would address nothing; never issue it.
        tgt_ok   = int'(up_target_i) < NUM_TARGETS;
        issue    = up_req_i && room && same && tgt_ok;
        accept   = issue && down_addr_ok_i[up_target_i];
        stray    = ((down_data_ok_i & ~cur_mask) != '0) ||
                   (down_data_ok_i[cur_q] && (cnt_q == '0));

        down_req_o   = issue ? (NUM_TARGETS'(1) << up_target_i) : '0;
        up_addr_ok_o = accept;
        up_data_ok_o = resp;
        up_rdata_o   = down_rdata_i[int'(cur_q)*DATA_W +: DATA_W];
        err_stray_o  = err_q;
    end

    // Next-state for outstanding count, owning target and sticky stray flag.
    always_comb begin
        cnt_d = cnt_q;
        if (accept && !resp) begin
            cnt_d = cnt_q + CW'(1);
        end else if (!accept && resp) begin
            cnt_d = cnt_q - CW'(1);
        end
        cur_d = accept ? up_target_i : cur_q;
        err_d = err_q || stray;
    end

    // State registers; reset discards anything still in flight.
    always_ff @(posedge clk_i or posedge reset_i) begin
        if (reset_i) begin
            cnt_q <= '0;
            cur_q <= '0;
            err_q <= 1'b0;
        end else begin
            cnt_q <= cnt_d;
            cur_q <= cur_d;
            err_q <= err_d;
        end
    end

endmodule

// File: doc/dbus_dispatch.md
# dbus_dispatch

Parametrised data-bus dispatcher between the CPU data port and NUM_TARGETS downstream data-bus slaves (cached path, uncached path, further device windows). It routes each request to the target chosen by the translation stage, tracks up to DEPTH outstanding transactions, and returns responses to the CPU strictly in order. This generalises the two-target, single-outstanding dcache/uncached split to N targets and multi-outstanding pipelining. It adds a drain-on-switch ordering rule and stray-response detection.

## Interface
- NUM_TARGETS, 2: number of downstream slaves, ≥1; TW = max(1, $clog2(NUM_TARGETS))
- DEPTH, 2: max outstanding accepted-but-unanswered transactions, ≥1; CW = $clog2(DEPTH+1)
- ADDR_W, 32: physical address width
- DATA_W, 32: data width; SW = DATA_W/8
- clk  in  1  clock, all state on posedge
- reset  in  1  asynchronous, active-high
- up_req  in  1  CPU request valid
- up_wr  in  1  write when 1
- up_size  in  2  access size
- up_addr  in  ADDR_W  physical address, already translated
- up_strobe  in  SW  byte enables
- up_wdata  in  DATA_W  write data
- up_target  in  TW  destination slave index, valid with up_req
- up_addr_ok  out  1  request accepted this cycle
- up_data_ok  out  1  response for oldest outstanding transaction
- up_rdata  out  DATA_W  read data, valid with up_data_ok
- down_req  out  NUM_TARGETS  per-target request valid, one-hot or zero
- down_wr, down_size, down_addr, down_strobe, down_wdata  out  as up_*  broadcast copies of up_* fields
- down_addr_ok  in  NUM_TARGETS  per-target accept
- down_data_ok  in  NUM_TARGETS  per-target response
- down_rdata  in  NUM_TARGETS*DATA_W  per-target read data, target i at [i*DATA_W +: DATA_W]
- err_stray  out  1  sticky: response arrived from a target with nothing outstanding

## Operation
- State: cnt (CW bits, outstanding count), cur (TW bits, target owning all outstanding transactions), err_stray.
- resp = down_data_ok[cur] && cnt != 0. up_data_ok = resp; up_rdata = down_rdata slice of cur. Both are combinational.
- room = (cnt < DEPTH) || resp. The full-bypass rule lets a response free a slot in the same cycle.
- same = (cnt == 0) || (up_target == cur) || (cnt == 1 && resp). The drain bypass lets the target switch in the cycle the last response returns.
- issue = up_req && room && same. down_req[up_target] = issue; all other down_req bits are 0. If !issue, down_req is all-zero.
- up_addr_ok = issue && down_addr_ok[up_target]. An accept is counted only on this condition.
- Every cycle with up_addr_ok high is a new transaction. The CPU holding up_req after an accept issues a further request.
- cnt_next = cnt + accept − resp. A simultaneous accept and resp leaves cnt unchanged.
- On accept, cur <= up_target. When cnt ≥ 1 with no drain bypass, this is a no-op because same forces equality.
- Stray condition: down_data_ok[i] for any i ≠ cur, or down_data_ok[cur] while cnt == 0.
  - The stray response is not forwarded to the CPU.
  - err_stray <= 1 and holds until reset.
- Ordering guarantee: all outstanding transactions target one slave. Each slave answers in order, so CPU responses are in order.

## Timing
- Reset (async assert): cnt=0, cur=0, err_stray=0. With up_req=0 and downstream quiet, all outputs are 0.
- Reset mid-operation drops outstanding transactions. Downstream responses arriving after deassert are strays and set err_stray.
- Request path is combinational. up_addr_ok can rise in the same cycle as up_req; minimum latency is 0 cycles added.
- Response path is combinational. up_data_ok follows down_data_ok[cur] in the same cycle.
- Throughput: one accept per cycle while room and same hold. With DEPTH=1, back-to-back accepts need resp in the same cycle.
- Target switch with cnt ≥ 2 stalls. up_addr_ok and down_req stay 0 until cnt reaches 1 with resp, or cnt reaches 0.
- Counter never exceeds DEPTH and never underflows; resp requires cnt ≠ 0.

## Test plan
- Reset, then one read to target 0 with down_addr_ok=1 and down_data_ok[0]=1 with rdata 0xDEADBEEF two cycles later. Required: up_addr_ok in cycle 0, cnt 1 then 0, up_data_ok with up_rdata=0xDEADBEEF, err_stray=0.
- DEPTH=2, three back-to-back requests to target 1 with no responses. Required: first two accepted; third sees down_req=0 and up_addr_ok=0. When down_data_ok[1] arrives, the third is accepted in the same cycle and cnt stays 2.
- Two requests to target 0 outstanding, then a request to target 1. Required: stall until the first response (cnt=1). The second response and the target-1 accept happen in the same cycle; cur becomes 1 and cnt=1.
- Simultaneous accept and response on target 0 at cnt=1 for five cycles. Required: cnt constant at 1; five up_data_ok pulses in order.
- down_data_ok[1] pulsed while cur=0 and cnt=1. Required: up_data_ok=0, err_stray=1 next cycle, cnt unchanged, err_stray stays 1 until reset.
- Reset asserted with cnt=2, then a late down_data_ok[0] after deassert. Required: outputs 0 during reset, up_data_ok=0, err_stray=1.
